// File: rtl/seq_divider_pkg.sv
// Shared types and width constants for the sequential restoring divider.
package seq_divider_pkg;

  localparam int N_DEF = 4;

  // Bits needed to count the 2N quotient steps down to zero.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(2 * n);
  endfunction

  localparam int XW_DEF = 2 * N_DEF;
  localparam int PW_DEF = N_DEF + 1;
  localparam int CW_DEF = cnt_width(N_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle between a requester (master) and the divider (slave).
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int N = N_DEF
);
  // Both channels use valid/ready: a transfer happens on the rising edge where
  // valid and ready are both high; valid and its payload must hold until then.
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   x;
  logic [N-1:0]     y;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   q;
  logic [N-1:0]     r;
  logic             dz;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, q, r, dz
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, q, r, dz
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract y, keep or restore.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N:0]   i_pr,
  input  logic         i_msb,
  input  logic [N-1:0] i_y,
  output logic [N:0]   o_pr,
  output logic         o_qbit
);

  logic [N:0] w_trial;
  logic [N:0] w_diff;
  logic       w_unused_pr_msb;

  // The held remainder is always below 2^N, so its top bit never feeds the shift.
  assign w_unused_pr_msb = i_pr[N];

  assign w_trial = {i_pr[N-1:0], i_msb};
  assign w_diff  = w_trial - {1'b0, i_y};
  assign o_qbit  = (w_trial >= {1'b0, i_y});
  assign o_pr    = o_qbit ? w_diff : w_trial;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per cycle.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips CALC and completes on the accept edge.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus,
  output state_t       o_dbg_state
);

  localparam int XW = 2 * N;
  localparam int CW = cnt_width(N);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [XW-1:0] r_sh;
  logic [N-1:0]  r_y;
  logic [N:0]    r_pr;
  logic [CW-1:0] r_cnt;
  logic [XW-1:0] r_q;
  logic [N-1:0]  r_r;
  logic          r_dz;

  logic          w_accept;
  logic          w_last;
  logic          w_qbit;
  logic [N:0]    w_pr_nxt;
  logic [XW-1:0] w_sh_nxt;

  assign w_accept = bus.in_valid && (r_state == ST_IDLE);
  assign w_last   = (r_cnt == '0);
  // Quotient bits enter at the LSB as dividend bits leave at the MSB.
  assign w_sh_nxt = {r_sh[XW-2:0], w_qbit};

  div_step #(.N(N)) u_step (
    .i_pr   (r_pr),
    .i_msb  (r_sh[XW-1]),
    .i_y    (r_y),
    .o_pr   (w_pr_nxt),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
`ifdef DIV_ZERO_FAST_EN
          w_state_nxt = (bus.y == '0) ? ST_DONE : ST_CALC;
`else
          w_state_nxt = ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh  <= '0;
      r_y   <= '0;
      r_pr  <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dz  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sh  <= bus.x;
            r_y   <= bus.y;
            r_pr  <= '0;
            r_cnt <= CW'(XW - 1);
`ifdef DIV_ZERO_FAST_EN
            if (bus.y == '0) begin
              r_q  <= '1;
              r_r  <= bus.x[N-1:0];
              r_dz <= 1'b1;
            end
`endif
          end
        end
        ST_CALC: begin
          r_pr  <= w_pr_nxt;
          r_sh  <= w_sh_nxt;
          r_cnt <= r_cnt - CW'(1);
          // Final step: publish the result from this step's values, not the stale registers.
          if (w_last) begin
            r_q  <= w_sh_nxt;
            r_r  <= w_pr_nxt[N-1:0];
            r_dz <= (r_y == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.q         = r_q;
  assign bus.r         = r_r;
  assign bus.dz        = r_dz;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=4) against an arithmetic reference model.
module tb_seq_divider;
  import seq_divider_pkg::*;

  localparam int N  = 4;
  localparam int XW = 2 * N;
`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST_DZ = 1'b1;
`else
  localparam bit FAST_DZ = 1'b0;
`endif

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     cyc;
  int     n_checks;
  int     n_pass;

  // Expected {q, r, dz} per issued operation, and the operands that produced it.
  logic [XW+N:0]   exp_q[$];
  logic [XW+N-1:0] op_q[$];

  seq_divider_if #(.N(N)) bus ();

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [XW+N:0] model(input logic [XW-1:0] xv, input logic [N-1:0] yv);
    int qi;
    int ri;
    if (yv == '0) return {{XW{1'b1}}, xv[N-1:0], 1'b1};
    qi = int'(xv) / int'(yv);
    ri = int'(xv) % int'(yv);
    return {XW'(qi), N'(ri), 1'b0};
  endfunction

  function automatic int exp_latency(input logic [N-1:0] yv);
    return (FAST_DZ && (yv == '0)) ? 1 : 2 * N + 1;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 with out_valid high or a timeout.
  task automatic do_op(input logic [XW-1:0] xv, input logic [N-1:0] yv,
                       output int lat, output logic ok);
    int w;
    bus.x        = xv;
    bus.y        = yv;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = bus.out_valid;
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if ({bus.q, bus.r, bus.dz} !== '0) $display("FAIL reset_outputs: got q=%0d r=%0d dz=%b want 0/0/0", bus.q, bus.r, bus.dz); else n_pass++;
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_known_vectors();
    logic [XW-1:0] xs[7];
    logic [N-1:0]  ys[7];
    logic [XW+N:0] exp_v;
    int            lat;
    logic          ok;
    xs = '{8'd143, 8'd255, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0};
    ys = '{4'd11, 4'd1, 4'd9, 4'd1, 4'd1, 4'd1, 4'd1};
    for (int i = 3; i < 7; i++) begin
      xs[i] = XW'($urandom_range(255, 0));
      ys[i] = N'($urandom_range(15, 1));
    end
    for (int i = 0; i < 7; i++) begin
      do_op(xs[i], ys[i], lat, ok);
      exp_v = model(xs[i], ys[i]);
      n_checks++;
      if (!ok) $display("FAIL vec%0d_done: out_valid never rose", i);
      else n_pass++;
      n_checks++;
      if ({bus.q, bus.r, bus.dz} !== exp_v)
        $display("FAIL vec%0d_result x=%0d y=%0d: got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                 i, xs[i], ys[i], bus.q, bus.r, bus.dz, exp_v[XW+N:N+1], exp_v[N:1], exp_v[0]);
      else n_pass++;
      n_checks++;
      if (lat != exp_latency(ys[i])) $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, exp_latency(ys[i]));
      else n_pass++;
      retire();
    end
  endtask

  task automatic test_div_zero();
    int   lat;
    logic ok;
    do_op(8'd200, 4'd0, lat, ok);
    n_checks++;
    if (!ok || bus.q !== 8'd255 || bus.r !== 4'd8 || bus.dz !== 1'b1)
      $display("FAIL div_zero_result: got q=%0d r=%0d dz=%b want q=255 r=8 dz=1", bus.q, bus.r, bus.dz);
    else n_pass++;
    n_checks++;
    if (lat != exp_latency(4'd0)) $display("FAIL div_zero_latency: got %0d want %0d", lat, exp_latency(4'd0));
    else n_pass++;
    retire();
  endtask

  task automatic test_hold();
    int            lat;
    logic          ok;
    logic          stable;
    logic [XW-1:0] q_snap;
    logic [N-1:0]  r_snap;
    do_op(8'd200, 4'd13, lat, ok);
    q_snap = bus.q;
    r_snap = bus.r;
    n_checks++;
    if (!ok || {q_snap, r_snap} !== {8'd15, 4'd5})
      $display("FAIL hold_result: got q=%0d r=%0d want q=15 r=5", q_snap, r_snap);
    else n_pass++;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.q !== q_snap || bus.r !== r_snap || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
        stable = 1'b0;
    end
    n_checks++;
    if (stable !== 1'b1) $display("FAIL hold_stable: got %b want 1", stable);
    else n_pass++;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL hold_release: got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int   lat;
    logic ok;
    bus.x        = 8'd100;
    bus.y        = 4'd3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.q !== '0 || bus.r !== '0 || bus.dz !== 1'b0)
      $display("FAIL mid_reset: got in_ready=%b out_valid=%b q=%0d r=%0d dz=%b want 1/0/0/0/0",
               bus.in_ready, bus.out_valid, bus.q, bus.r, bus.dz);
    else n_pass++;
    do_op(8'd100, 4'd3, lat, ok);
    n_checks++;
    if (!ok || bus.q !== 8'd33 || bus.r !== 4'd1 || lat != 2 * N + 1)
      $display("FAIL after_reset_op: got q=%0d r=%0d lat=%0d want q=33 r=1 lat=%0d", bus.q, bus.r, lat, 2 * N + 1);
    else n_pass++;
    retire();
  endtask

  task automatic test_back_to_back();
    logic [XW-1:0] xs[3];
    logic [N-1:0]  ys[3];
    int            acc_cyc[3];
    int            n_acc;
    int            n_res;
    logic [XW+N:0] exp_v;
    xs = '{8'd143, 8'd77, 8'd250};
    ys = '{4'd11, 4'd5, 4'd15};
    exp_q.delete();
    n_acc = 0;
    n_res = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.x = xs[0];
    bus.y = ys[0];
    for (int t = 0; t < 60 && n_res < 3; t++) begin
      if (bus.out_valid) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_checks++;
        if ({bus.q, bus.r, bus.dz} !== exp_v)
          $display("FAIL b2b_result%0d: got q=%0d r=%0d want q=%0d r=%0d", n_res, bus.q, bus.r, exp_v[XW+N:N+1], exp_v[N:1]);
        else n_pass++;
        n_res++;
      end
      if (bus.in_valid && bus.in_ready) begin
        acc_cyc[n_acc] = cyc;
        exp_q.push_back(model(bus.x, bus.y));
        n_acc++;
      end
      @(posedge clk); #1;
      if (n_acc < 3) begin
        bus.x = xs[n_acc];
        bus.y = ys[n_acc];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_checks++;
    if (n_res != 3 || n_acc != 3) $display("FAIL b2b_count: got %0d results %0d accepts want 3/3", n_res, n_acc);
    else n_pass++;
    n_checks++;
    if (acc_cyc[1] - acc_cyc[0] != 2 * N + 2 || acc_cyc[2] - acc_cyc[1] != 2 * N + 2)
      $display("FAIL b2b_period: got %0d,%0d want %0d", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1], 2 * N + 2);
    else n_pass++;
  endtask

  task automatic test_sweep();
    int              order[4096];
    int              tmp;
    int              j;
    int              n_got;
    int              budget;
    logic            abort;
    logic [XW+N:0]   exp_v;
    logic [XW+N-1:0] op_v;
    int              qi;
    int              ri;
    int              yi;
    for (int i = 0; i < 4096; i++) order[i] = i;
    for (int i = 4095; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    exp_q.delete();
    op_q.delete();
    n_got  = 0;
    abort  = 1'b0;
    budget = cyc + 80000;
    fork
      begin
        for (int k = 0; k < 4096 && !abort; k++) begin
          bus.x = order[k][11:4];
          bus.y = order[k][3:0];
          bus.in_valid = 1'b1;
          while (!bus.in_ready && cyc < budget) begin
            @(posedge clk); #1;
          end
          if (!bus.in_ready) begin
            abort = 1'b1;
          end else begin
            exp_q.push_back(model(bus.x, bus.y));
            op_q.push_back({bus.x, bus.y});
            @(posedge clk); #1;
          end
        end
        bus.in_valid = 1'b0;
      end
      begin
        while (n_got < 4096 && !abort && cyc < budget) begin
          bus.out_ready = ($urandom_range(3, 0) != 0);
          if (bus.out_valid && bus.out_ready) begin
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            op_v  = (op_q.size() > 0) ? op_q.pop_front() : '0;
            n_checks++;
            if ({bus.q, bus.r, bus.dz} !== exp_v)
              $display("FAIL sweep_result x=%0d y=%0d: got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                       op_v[XW+N-1:N], op_v[N-1:0], bus.q, bus.r, bus.dz, exp_v[XW+N:N+1], exp_v[N:1], exp_v[0]);
            else n_pass++;
            yi = int'(op_v[N-1:0]);
            if (yi != 0) begin
              qi = int'(bus.q);
              ri = int'(bus.r);
              n_checks++;
              if (qi * yi + ri != int'(op_v[XW+N-1:N]) || ri >= yi)
                $display("FAIL sweep_identity x=%0d y=%0d: got q*y+r=%0d r=%0d", op_v[XW+N-1:N], yi, qi * yi + ri, ri);
              else n_pass++;
            end
            n_got++;
          end
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
      end
    join
    n_checks++;
    if (n_got != 4096) $display("FAIL sweep_count: got %0d results want 4096", n_got);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    cyc           = 0;
    n_checks      = 0;
    n_pass        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    test_reset();
    test_known_vectors();
    test_div_zero();
    test_hold();
    test_mid_reset();
    test_back_to_back();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
